// File: rtl/tft_timing_pkg.sv
// Shared types and default 800x480 panel timing for the TFT raster generator.
// Also holds helpers that size the axis counters from the segment widths.
package tft_timing_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_BACK   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FRONT  = 2'd3
  } axis_state_t;

  localparam int DEF_H_SYNC   = 1;
  localparam int DEF_H_BACK   = 45;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 17;
  localparam int DEF_V_SYNC   = 1;
  localparam int DEF_V_BACK   = 22;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 11;

  function automatic int axis_total(input int s, input int b, input int a, input int f);
    return s + b + a + f;
  endfunction

  function automatic int cnt_width(input int total);
    return (total > 2) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/tft_axis_timer.sv
// One raster axis: position counter plus SYNC->BACK->ACTIVE->FRONT segment FSM.
// Everything advances only on i_tick; o_last flags the terminal count.
module tft_axis_timer
  import tft_timing_pkg::*;
#(
  parameter int SYNC   = 1,
  parameter int BACK   = 1,
  parameter int ACTIVE = 1,
  parameter int FRONT  = 1,
  localparam int TOTAL = axis_total(SYNC, BACK, ACTIVE, FRONT),
  localparam int CW    = cnt_width(TOTAL)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_tick,
  output logic [CW-1:0] o_cnt,
  output logic [1:0]    o_state,
  output logic          o_last
);

  if (SYNC < 1 || BACK < 1 || ACTIVE < 1 || FRONT < 1) begin : g_bad_segment
    $error("tft_axis_timer: every segment must be at least one unit wide");
  end

  axis_state_t   r_state;
  axis_state_t   w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_seg;
  logic [CW-1:0] w_seg_end;
  logic          w_seg_done;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_SYNC;
      r_cnt   <= '0;
      r_seg   <= '0;
    end else if (i_tick) begin
      r_state <= w_state_next;
      r_cnt   <= o_last ? '0 : r_cnt + 1'b1;
      r_seg   <= w_seg_done ? '0 : r_seg + 1'b1;
    end
  end

  // Segment length of the current state decides when to move on.
  always_comb begin
    w_seg_end    = CW'(SYNC - 1);
    w_state_next = r_state;
    case (r_state)
      ST_SYNC:   begin w_seg_end = CW'(SYNC - 1);   w_state_next = ST_BACK;   end
      ST_BACK:   begin w_seg_end = CW'(BACK - 1);   w_state_next = ST_ACTIVE; end
      ST_ACTIVE: begin w_seg_end = CW'(ACTIVE - 1); w_state_next = ST_FRONT;  end
      ST_FRONT:  begin w_seg_end = CW'(FRONT - 1);  w_state_next = ST_SYNC;   end
      default:   begin w_seg_end = CW'(SYNC - 1);   w_state_next = ST_SYNC;   end
    endcase
    w_seg_done = (r_seg == w_seg_end);
    if (!w_seg_done) begin
      w_state_next = r_state;
    end
  end

  always_comb begin
    o_cnt   = r_cnt;
    o_state = r_state;
    o_last  = (r_cnt == CW'(TOTAL - 1));
  end

endmodule

// File: rtl/tft_timing_gen.sv
// RGB-TFT raster timing generator: HS/VS/DE, active x/y, line/frame markers, DISP.
// Run starts and stops only on frame boundaries; all outputs carry one cycle of latency.
module tft_timing_gen
  import tft_timing_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           i_en,
  output logic           o_dclk,
  output logic           o_hs,
  output logic           o_vs,
  output logic           o_de,
  output logic           o_disp,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_line_start,
  output logic           o_frame_start
);

  localparam int H_TOTAL = axis_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOTAL = axis_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam int HCW     = cnt_width(H_TOTAL);
  localparam int VCW     = cnt_width(V_TOTAL);
  localparam int H_OFF   = H_SYNC + H_BACK;
  localparam int V_OFF   = V_SYNC + V_BACK;

  if (X_W < $clog2(H_ACTIVE) || Y_W < $clog2(V_ACTIVE)) begin : g_bad_coord_width
    $error("tft_timing_gen: X_W/Y_W too narrow for the active area");
  end

  logic           r_run;
  logic           r_hs;
  logic           r_vs;
  logic           r_de;
  logic           r_disp;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_line_start;
  logic           r_frame_start;

  logic [HCW-1:0] w_h_cnt;
  logic [VCW-1:0] w_v_cnt;
  logic [1:0]     w_h_state;
  logic [1:0]     w_v_state;
  logic           w_h_last;
  logic           w_v_last;
  logic           w_v_tick;
  logic           w_frame_end;
  logic           w_de;
  logic           w_line_start;
  logic           w_frame_start;

  tft_axis_timer #(
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT)
  ) u_h_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_tick  (r_run),
    .o_cnt   (w_h_cnt),
    .o_state (w_h_state),
    .o_last  (w_h_last)
  );

  tft_axis_timer #(
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT)
  ) u_v_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_tick  (w_v_tick),
    .o_cnt   (w_v_cnt),
    .o_state (w_v_state),
    .o_last  (w_v_last)
  );

  assign w_v_tick      = r_run && w_h_last;
  assign w_frame_end   = w_v_tick && w_v_last;
  assign w_de          = r_run && (w_h_state == ST_ACTIVE) && (w_v_state == ST_ACTIVE);
  assign w_line_start  = r_run && (w_h_cnt == '0);
  assign w_frame_start = w_line_start && (w_v_cnt == '0);

  // en is only honoured while idle or on the last cycle of a frame.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_run <= 1'b0;
    end else if (!r_run || w_frame_end) begin
      r_run <= i_en;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_de          <= 1'b0;
      r_disp        <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hs          <= (r_run && w_h_state == ST_SYNC) ? HS_POL : ~HS_POL;
      r_vs          <= (r_run && w_v_state == ST_SYNC) ? VS_POL : ~VS_POL;
      r_de          <= w_de;
      r_x           <= w_de ? X_W'(w_h_cnt - HCW'(H_OFF)) : '0;
      r_y           <= w_de ? Y_W'(w_v_cnt - VCW'(V_OFF)) : '0;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
      r_disp        <= r_run && (w_frame_start || r_disp);
    end
  end

  assign o_dclk        = i_clock;
  assign o_hs          = r_hs;
  assign o_vs          = r_vs;
  assign o_de          = r_de;
  assign o_disp        = r_disp;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule
